// File: rtl/muldiv_ctrl.sv
// Sequencing controller for the EXE-stage multiplier/divider; owns the architectural HI/LO.
// Optional: define MULDIV_DIVZERO_FAST_EN to commit divide-by-zero without starting the divider.
module muldiv_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic        req_ready,
  input  logic        cancel,
  output logic        resp_valid,
  output logic        busy,
  output logic        err,
  output logic        mul_start,
  output logic        mul_signed,
  output logic [31:0] mul_op1,
  output logic [31:0] mul_op2,
  input  logic        mul_done,
  input  logic [63:0] mul_product,
  output logic        div_start,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_done,
  input  logic [31:0] div_quot,
  input  logic [31:0] div_rem,
  output logic        unit_flush,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  localparam logic [2:0] OpMthi  = 3'b001;
  localparam logic [2:0] OpMtlo  = 3'b010;
  localparam logic [2:0] OpMult  = 3'b100;
  localparam logic [2:0] OpMultu = 3'b101;
  localparam logic [2:0] OpDiv   = 3'b110;
  localparam logic [2:0] OpDivu  = 3'b111;

  typedef enum logic [2:0] {StIdle, StMulWait, StDivWait, StFixup, StCommit} state_e;

  state_e          state_q, state_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic            err_q, err_d;
  logic            mul_start_q, mul_start_d;
  logic            div_start_q, div_start_d;
  logic            flush_q, flush_d;
  logic            mul_signed_q, mul_signed_d;
  logic [31:0]     mul_op1_q, mul_op1_d, mul_op2_q, mul_op2_d;
  logic [31:0]     div_a_q, div_a_d, div_b_q, div_b_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            div_signed_q, div_signed_d;
  logic            neg_quot_q, neg_quot_d, neg_rem_q, neg_rem_d;
  logic [31:0]     quot_q, quot_d, rem_q, rem_d;
  logic            op_legal, accept, div_fast;

  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

`ifdef MULDIV_DIVZERO_FAST_EN
  assign div_fast = (req_src2 == 32'd0);
`else
  assign div_fast = 1'b0;
`endif

  always_comb begin
    op_legal = 1'b0;
    case (req_op)
      OpMthi, OpMtlo, OpMult, OpMultu, OpDiv, OpDivu: op_legal = 1'b1;
      default:                                       op_legal = 1'b0;
    endcase
  end

  assign accept = req_valid && (state_q == StIdle) && op_legal;

  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    err_d        = err_q;
    mul_start_d  = 1'b0;
    div_start_d  = 1'b0;
    flush_d      = 1'b0;
    mul_signed_d = mul_signed_q;
    mul_op1_d    = mul_op1_q;
    mul_op2_d    = mul_op2_q;
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;
    cnt_d        = cnt_q;
    div_signed_d = div_signed_q;
    neg_quot_d   = neg_quot_q;
    neg_rem_d    = neg_rem_q;
    quot_d       = quot_q;
    rem_d        = rem_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (req_op)
            OpMthi: begin
              hi_d    = req_src1;
              state_d = StCommit;
            end
            OpMtlo: begin
              lo_d    = req_src1;
              state_d = StCommit;
            end
            OpMult, OpMultu: begin
              mul_signed_d = (req_op == OpMult);
              mul_op1_d    = req_src1;
              mul_op2_d    = req_src2;
              mul_start_d  = 1'b1;
              cnt_d        = '0;
              state_d      = StMulWait;
            end
            default: begin
              if (div_fast) begin
                hi_d    = req_src1;
                lo_d    = 32'hFFFF_FFFF;
                state_d = StCommit;
              end else begin
                div_signed_d = (req_op == OpDiv);
                div_a_d      = (req_op == OpDiv) ? abs32(req_src1) : req_src1;
                div_b_d      = (req_op == OpDiv) ? abs32(req_src2) : req_src2;
                neg_quot_d   = (req_op == OpDiv) && (req_src1[31] ^ req_src2[31]);
                neg_rem_d    = (req_op == OpDiv) && req_src1[31];
                div_start_d  = 1'b1;
                cnt_d        = '0;
                state_d      = StDivWait;
              end
            end
          endcase
        end
      end
      // Priority in both WAIT states: cancel, then done, then watchdog.
      StMulWait: begin
        if (cancel) begin
          flush_d = 1'b1;
          state_d = StIdle;
        end else if (mul_done) begin
          hi_d    = mul_product[63:32];
          lo_d    = mul_product[31:0];
          state_d = StCommit;
        end else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          flush_d = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDivWait: begin
        if (cancel) begin
          flush_d = 1'b1;
          state_d = StIdle;
        end else if (div_done) begin
          if (div_signed_q) begin
            quot_d  = div_quot;
            rem_d   = div_rem;
            state_d = StFixup;
          end else begin
            lo_d    = div_quot;
            hi_d    = div_rem;
            state_d = StCommit;
          end
        end else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          flush_d = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFixup: begin
        if (cancel) begin
          flush_d = 1'b1;
          state_d = StIdle;
        end else begin
          lo_d    = neg_quot_q ? neg32(quot_q) : quot_q;
          hi_d    = neg_rem_q ? neg32(rem_q) : rem_q;
          state_d = StCommit;
        end
      end
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      hi_q         <= '0;
      lo_q         <= '0;
      err_q        <= 1'b0;
      mul_start_q  <= 1'b0;
      div_start_q  <= 1'b0;
      flush_q      <= 1'b0;
      mul_signed_q <= 1'b0;
      mul_op1_q    <= '0;
      mul_op2_q    <= '0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      cnt_q        <= '0;
      div_signed_q <= 1'b0;
      neg_quot_q   <= 1'b0;
      neg_rem_q    <= 1'b0;
      quot_q       <= '0;
      rem_q        <= '0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      err_q        <= err_d;
      mul_start_q  <= mul_start_d;
      div_start_q  <= div_start_d;
      flush_q      <= flush_d;
      mul_signed_q <= mul_signed_d;
      mul_op1_q    <= mul_op1_d;
      mul_op2_q    <= mul_op2_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
      cnt_q        <= cnt_d;
      div_signed_q <= div_signed_d;
      neg_quot_q   <= neg_quot_d;
      neg_rem_q    <= neg_rem_d;
      quot_q       <= quot_d;
      rem_q        <= rem_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign resp_valid = (state_q == StCommit);
  assign err        = err_q;
  assign mul_start  = mul_start_q;
  assign mul_signed = mul_signed_q;
  assign mul_op1    = mul_op1_q;
  assign mul_op2    = mul_op2_q;
  assign div_start  = div_start_q;
  assign div_a      = div_a_q;
  assign div_b      = div_b_q;
  assign unit_flush = flush_q;
  assign hi         = hi_q;
  assign lo         = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with behavioural multiplier/divider models.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_src1, req_src2;
  logic        req_ready, cancel, resp_valid, busy, err;
  logic        mul_start, mul_signed, mul_done;
  logic [31:0] mul_op1, mul_op2;
  logic [63:0] mul_product;
  logic        div_start, div_done;
  logic [31:0] div_a, div_b, div_quot, div_rem;
  logic        unit_flush;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;
  int mul_lat = 4;
  int div_lat = 3;
  logic div_hang = 1'b0;
  int mcnt = 0;
  int dcnt = 0;

  muldiv_ctrl #(.TIMEOUT(64)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_src1   (req_src1),
    .req_src2   (req_src2),
    .req_ready  (req_ready),
    .cancel     (cancel),
    .resp_valid (resp_valid),
    .busy       (busy),
    .err        (err),
    .mul_start  (mul_start),
    .mul_signed (mul_signed),
    .mul_op1    (mul_op1),
    .mul_op2    (mul_op2),
    .mul_done   (mul_done),
    .mul_product(mul_product),
    .div_start  (div_start),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_done   (div_done),
    .div_quot   (div_quot),
    .div_rem    (div_rem),
    .unit_flush (unit_flush),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  // Multiplier model: done arrives mul_lat cycles after the mul_start cycle.
  initial begin
    mul_done = 1'b0;
    mul_product = '0;
  end
  always @(posedge clk) begin
    logic [63:0] ea, eb;
    mul_done <= 1'b0;
    if (mul_start) begin
      ea = mul_signed ? {{32{mul_op1[31]}}, mul_op1} : {32'd0, mul_op1};
      eb = mul_signed ? {{32{mul_op2[31]}}, mul_op2} : {32'd0, mul_op2};
      mul_product <= ea * eb;
      if (mul_lat == 1) mul_done <= 1'b1;
      else mcnt <= mul_lat - 1;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) mul_done <= 1'b1;
    end
  end

  initial begin
    div_done = 1'b0;
    div_quot = '0;
    div_rem  = '0;
  end
  always @(posedge clk) begin
    div_done <= 1'b0;
    if (unit_flush) begin
      dcnt <= 0;
    end else if (div_start && !div_hang) begin
      div_quot <= (div_b == 32'd0) ? 32'hFFFF_FFFF : div_a / div_b;
      div_rem  <= (div_b == 32'd0) ? div_a : div_a % div_b;
      if (div_lat == 1) div_done <= 1'b1;
      else dcnt <= div_lat - 1;
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) div_done <= 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    tick();
    req_valid = 1'b0;
    req_op    = 3'b000;
    req_src1  = '0;
    req_src2  = '0;
  endtask

  // Called in the cycle after accept; returns latency in cycles from the accept cycle.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int lat;
    int seen;
    resetn = 1'b0;
    req_valid = 1'b0;
    req_op = 3'b000;
    req_src1 = '0;
    req_src2 = '0;
    cancel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_err", err, 0);
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_pulses", {resp_valid, mul_start, div_start, unit_flush}, 0);
    check("rst_ops", {mul_op1, div_a}, 0);
    resetn = 1'b1;
    tick();

    // MTHI / MTLO
    do_req(3'b001, 32'h1234_5678, 32'h0);
    wait_resp(lat);
    check("mthi_lat", lat, 1);
    check("mthi_hi", hi, 32'h1234_5678);
    tick();
    check("b2b_ready", req_ready, 1);
    do_req(3'b010, 32'hCAFE_BABE, 32'h0);
    wait_resp(lat);
    check("mtlo_lat", lat, 1);
    check("mtlo_lo", lo, 32'hCAFE_BABE);
    check("mtlo_hi_kept", hi, 32'h1234_5678);
    tick();

    // MULT / MULTU with a 4-cycle multiplier
    do_req(3'b100, 32'hFFFF_FFFE, 32'h3);
    check("mult_start", mul_start, 1);
    check("mult_signed", mul_signed, 1);
    check("mult_ops", {mul_op1, mul_op2}, {32'hFFFF_FFFE, 32'h3});
    tick();
    check("mult_start_once", mul_start, 0);
    wait_resp(lat);
    check("mult_lat", lat + 1, 6);
    check("mult_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
    tick();
    do_req(3'b101, 32'hFFFF_FFFE, 32'h3);
    check("multu_signed", mul_signed, 0);
    wait_resp(lat);
    check("multu_lat", lat, 6);
    check("multu_hilo", {hi, lo}, {32'h2, 32'hFFFF_FFFA});
    tick();

    // Divides with a 3-cycle divider
    do_req(3'b110, 32'hFFFF_FFF9, 32'h2);
    check("div_start", div_start, 1);
    check("div_ops", {div_a, div_b}, {32'h7, 32'h2});
    wait_resp(lat);
    check("div_lat", lat, 6);
    check("div_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    tick();
    do_req(3'b111, 32'h7, 32'h2);
    wait_resp(lat);
    check("divu_lat", lat, 5);
    check("divu_hilo", {hi, lo}, {32'h1, 32'h3});
    tick();
    do_req(3'b110, 32'h7, 32'hFFFF_FFFE);
    wait_resp(lat);
    check("div_pos_neg", {hi, lo}, {32'h1, 32'hFFFF_FFFD});
    tick();
    do_req(3'b110, 32'h8000_0000, 32'h2);
    check("div_minint_a", div_a, 32'h8000_0000);
    wait_resp(lat);
    check("div_minint", {hi, lo}, {32'h0, 32'hC000_0000});
    tick();

    // Cancel in the same cycle as div_done
    do_req(3'b110, 32'd100, 32'd7);
    tick();
    tick();
    tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel_flush", unit_flush, 1);
    check("cancel_no_resp", resp_valid, 0);
    check("cancel_ready", req_ready, 1);
    check("cancel_hilo", {hi, lo}, {32'h0, 32'hC000_0000});
    tick();
    check("cancel_flush_once", unit_flush, 0);
    check("cancel_no_resp2", resp_valid, 0);

    // Cancel during COMMIT has no effect
    do_req(3'b001, 32'hAAAA_5555, 32'h0);
    cancel = 1'b1;
    check("commit_cancel_resp", resp_valid, 1);
    check("commit_cancel_hi", hi, 32'hAAAA_5555);
    tick();
    cancel = 1'b0;

    // Illegal op is never accepted
    do_req(3'b011, 32'h1, 32'h1);
    check("illegal_busy", busy, 0);
    check("illegal_ready", req_ready, 1);

    // Divide by zero
    do_req(3'b111, 32'd5, 32'd0);
`ifdef MULDIV_DIVZERO_FAST_EN
    check("dz_no_start", div_start, 0);
`endif
    wait_resp(lat);
`ifdef MULDIV_DIVZERO_FAST_EN
    check("dz_lat", lat, 1);
`else
    check("dz_lat", lat, 5);
`endif
    check("dz_hilo", {hi, lo}, {32'h5, 32'hFFFF_FFFF});
    tick();

    // Watchdog: divider never completes
    div_hang = 1'b1;
    seen = 0;
    do_req(3'b111, 32'd5, 32'd3);
    for (int i = 0; i < 63; i++) begin
      if (resp_valid === 1'b1) seen++;
      tick();
    end
    check("wd_busy_before", busy, 1);
    check("wd_err_before", err, 0);
    tick();
    check("wd_err", err, 1);
    check("wd_idle", busy, 0);
    check("wd_flush", unit_flush, 1);
    check("wd_no_resp", seen, 0);
    check("wd_hilo", {hi, lo}, {32'h5, 32'hFFFF_FFFF});
    div_hang = 1'b0;
    tick();
    do_req(3'b010, 32'h0BAD_F00D, 32'h0);
    check("err_sticky", err, 1);
    tick();

    // Reset mid-DIV_WAIT
    div_lat = 10;
    do_req(3'b111, 32'd9, 32'd4);
    tick();
    tick();
    resetn = 1'b0;
    #1;
    check("mid_rst_hilo", {hi, lo}, 64'h0);
    check("mid_rst_err", err, 0);
    check("mid_rst_ready", req_ready, 1);
    tick();
    resetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (resp_valid === 1'b1) seen++;
    end
    check("mid_rst_no_resp", seen, 0);
    check("mid_rst_hilo_after", {hi, lo}, 64'h0);
    check("mid_rst_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
